// File: rtl/fpu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpu_seq : EX-stage sequencer for the multi-cycle single-precision FPU.    |
// |           Enables the FPU for the op latency, stalls, hands off result.   |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module fpu_seq #(
  parameter int width    = 32,
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 6,
  parameter int LAT_CMP  = 1,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CVT  = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             ex_fp_valid,
  input  logic             flush,
  input  logic [3:0]       fpuOp,
  input  logic [width-1:0] fpu_result,
  output logic             fpu_sel,
  output logic             fpu_stall,
  output logic             fpu_done,
  output logic [width-1:0] wb_result
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [4:0]       cnt_q;
  logic [width-1:0] res_q;

  logic [4:0] w_lat;
  logic       w_req;
  logic       w_issue;
  logic       w_bypass;
  logic       w_run;

  always_comb begin
    w_lat = 5'd0;
    case (fpuOp)
      4'b0000, 4'b0001: w_lat = 5'(LAT_ADD);
      4'b0010:          w_lat = 5'(LAT_MUL);
      4'b0011:          w_lat = 5'(LAT_DIV);
      4'b0101, 4'b0111: w_lat = 5'(LAT_CMP);
      4'b0110:          w_lat = 5'(LAT_SQRT);
      4'b1000, 4'b1001: w_lat = 5'(LAT_CVT);
      default:          w_lat = 5'd0;
    endcase
  end

  // Issue and flush must act in the same cycle, so these outputs are decoded
  // combinationally from the registered state and the current EX inputs.
  assign w_req    = (state_q == ST_IDLE) && ex_fp_valid && !flush;
  assign w_issue  = w_req && (w_lat != 5'd0);
  assign w_bypass = w_req && (w_lat == 5'd0);
  assign w_run    = (state_q == ST_RUN) && !flush;

  assign fpu_sel   = w_issue | w_run;
  assign fpu_stall = w_issue | w_run;
  assign fpu_done  = w_bypass | (state_q == ST_DONE);
  assign wb_result = w_bypass ? fpu_result : res_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_issue) begin
            cnt_q   <= w_lat - 5'd1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else if (cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
          end else begin
            res_q   <= fpu_result;
            state_q <= ST_DONE;
          end
        end
        // The EX instruction is still the one completing, so no re-issue here.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
